adc_spi_capture: RTL and testbench

- Serial ADC front end for the pixel readout path.
- Sits downstream of the sensor pixel sequencer, which asserts start once a pixel is settled on the analog line.
- Drives the ADC chip-select and serial clock, shifts in one 16-bit frame from MISO, and presents a 12-bit sample with a one-cycle valid strobe.
- Its outputs feed the frame-buffer/PSRAM writer and the TP_adcStartCapture / TP_adcConvComplete test points.

---
 rtl/adc_spi_pkg.sv | 15 +
 rtl/adc_spi_sclk_gen.sv | 57 +++++
 rtl/adc_spi_capture.sv | 143 ++++++++++++++
 tb/tb_adc_spi_capture.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// Shared types and default frame geometry for the serial ADC capture front end.
package adc_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        QUIET
    } adc_state_t;

    localparam int unsigned FRAME_BITS_DEF = 16;
    localparam int unsigned DATA_BITS_DEF  = 12;
    localparam int unsigned LEAD_BITS      = FRAME_BITS_DEF - DATA_BITS_DEF;

endpackage

// File: rtl/adc_spi_sclk_gen.sv
// SCLK phase generator: divides CLK50 into SCLK half-periods and strobes the
// capture and end-of-bit points for the capture FSM. Honours ADC_SPI_MISO_SYNC_EN.
module adc_spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_setup,
    input  logic i_shift,
    input  logic i_last_bit,
    output logic o_sclk,
    output logic o_setup_done,
    output logic o_capture_en,
    output logic o_bit_done
);

    localparam logic [7:0] LP_PHASE_LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_phase;
    logic       w_phase_end;

    assign w_phase_end = (r_phase == LP_PHASE_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= '0;
            o_sclk  <= 1'b1;
        end else begin
            if (i_setup || i_shift)
                r_phase <= w_phase_end ? '0 : r_phase + 8'd1;
            else
                r_phase <= '0;

            // SCLK parks high after the final bit instead of starting another low phase
            if (i_setup && w_phase_end)
                o_sclk <= 1'b0;
            else if (i_shift && w_phase_end) begin
                if (!o_sclk)
                    o_sclk <= 1'b1;
                else if (!i_last_bit)
                    o_sclk <= 1'b0;
            end else if (!i_setup && !i_shift)
                o_sclk <= 1'b1;
        end
    end

    assign o_setup_done = i_setup && w_phase_end;
    assign o_bit_done   = i_shift && o_sclk && w_phase_end;

`ifdef ADC_SPI_MISO_SYNC_EN
    // Two cycles after the end of the low phase, matching the synchronizer delay
    assign o_capture_en = i_shift && o_sclk && (r_phase == 8'd1);
`else
    assign o_capture_en = i_shift && !o_sclk && w_phase_end;
`endif

endmodule

// File: rtl/adc_spi_capture.sv
// Serial ADC capture: CS/SCLK sequencing, MSB-first frame shift-in, 12-bit sample
// with valid strobe. Define ADC_SPI_MISO_SYNC_EN to add a two-flop MISO synchronizer.
module adc_spi_capture
    import adc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned FRAME_BITS   = FRAME_BITS_DEF,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEF,
    parameter int unsigned QUIET_CYCLES = 4
) (
    input  logic                 CLK50,
    input  logic                 MSS_RESET_N,
    input  logic                 start,
    input  logic                 MISO,
    output logic                 CS,
    output logic                 SCLK,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    output logic                 conv_complete,
    output logic                 frame_err,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned       LP_BCW        = $clog2(FRAME_BITS + 1);
    localparam logic [LP_BCW-1:0] LP_LAST_BIT   = LP_BCW'(FRAME_BITS - 1);
    localparam logic [7:0]        LP_QUIET_LAST = 8'(QUIET_CYCLES - 1);

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_div_range
        $error("adc_spi_capture: CLK_DIV must be 1..255");
    end
    if (QUIET_CYCLES < 1 || QUIET_CYCLES > 255) begin : g_quiet_range
        $error("adc_spi_capture: QUIET_CYCLES must be 1..255");
    end

    adc_state_t            r_state;
    logic [FRAME_BITS-1:0] r_shift;
    logic [LP_BCW-1:0]     r_bit_cnt;
    logic [7:0]            r_quiet_cnt;
    logic                  r_start_d;
    logic                  w_miso;
    logic                  w_last_bit;
    logic                  w_setup_done;
    logic                  w_capture_en;
    logic                  w_bit_done;

`ifdef ADC_SPI_MISO_SYNC_EN
    if (CLK_DIV < 3) begin : g_sync_div
        $error("adc_spi_capture: ADC_SPI_MISO_SYNC_EN requires CLK_DIV >= 3");
    end

    logic [1:0] r_miso_sync;

    always_ff @(posedge CLK50 or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N)
            r_miso_sync <= '0;
        else
            r_miso_sync <= {r_miso_sync[0], MISO};
    end

    assign w_miso = r_miso_sync[1];
`else
    assign w_miso = MISO;
`endif

    assign w_last_bit = (r_bit_cnt == LP_LAST_BIT);
    assign busy       = (r_state != IDLE);

    adc_spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .i_clk        (CLK50),
        .i_rst_n      (MSS_RESET_N),
        .i_setup      (r_state == SETUP),
        .i_shift      (r_state == SHIFT),
        .i_last_bit   (w_last_bit),
        .o_sclk       (SCLK),
        .o_setup_done (w_setup_done),
        .o_capture_en (w_capture_en),
        .o_bit_done   (w_bit_done)
    );

    always_ff @(posedge CLK50 or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_quiet_cnt   <= '0;
            r_start_d     <= 1'b0;
            CS            <= 1'b1;
            sample        <= '0;
            sample_valid  <= 1'b0;
            conv_complete <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            sample_valid  <= 1'b0;
            conv_complete <= 1'b0;
            frame_err     <= 1'b0;
            r_start_d     <= start;
            overrun       <= start && !r_start_d && (r_state != IDLE);

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SETUP;
                        CS      <= 1'b0;
                    end
                end
                SETUP: begin
                    if (w_setup_done)
                        r_state <= SHIFT;
                end
                SHIFT: begin
                    if (w_capture_en)
                        r_shift <= {r_shift[FRAME_BITS-2:0], w_miso};
                    if (w_bit_done) begin
                        if (w_last_bit) begin
                            r_state       <= QUIET;
                            r_bit_cnt     <= '0;
                            r_quiet_cnt   <= '0;
                            CS            <= 1'b1;
                            sample        <= r_shift[DATA_BITS-1:0];
                            sample_valid  <= 1'b1;
                            conv_complete <= 1'b1;
                            frame_err     <= |r_shift[FRAME_BITS-1:DATA_BITS];
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                QUIET: begin
                    if (r_quiet_cnt == LP_QUIET_LAST)
                        r_state <= IDLE;
                    else
                        r_quiet_cnt <= r_quiet_cnt + 8'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_capture.sv
// Scoreboard bench for adc_spi_capture: directed frames from a behavioural ADC,
// expected samples queued at start and checked by independent monitors.
module tb_adc_spi_capture;

`ifdef ADC_SPI_MISO_SYNC_EN
    localparam int A_DIV = 3;
`else
    localparam int A_DIV = 2;
`endif
    localparam int A_LAT = 1 + 33 * A_DIV;
    localparam int A_PER = A_LAT + 4;
    localparam int B_LAT = 1 + 33 * 4;

    typedef struct {
        logic [11:0] smp;
        logic        ferr;
        int          at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b, miso_a, miso_b;
    logic        cs_a, sclk_a, valid_a, conv_a, ferr_a, busy_a, ovr_a;
    logic        cs_b, sclk_b, valid_b, conv_b, ferr_b, busy_b, ovr_b;
    logic [11:0] sample_a, sample_b;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    logic [15:0] word_a, word_b;
    int   idx_a = 0, idx_b = 0, falls_a = 0, falls_b = 0;
    time  tf0_b, tf1_b;
    int   ovr_cnt = 0, ovr_last = -1;
    int   cs_first = -1, cs_last = -1;
    logic prev_cs = 1'b1;
    int   t, ov0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_spi_capture #(.CLK_DIV(A_DIV)) u_dut_a (
        .CLK50(clk), .MSS_RESET_N(rst_n), .start(start_a), .MISO(miso_a),
        .CS(cs_a), .SCLK(sclk_a), .sample(sample_a), .sample_valid(valid_a),
        .conv_complete(conv_a), .frame_err(ferr_a), .busy(busy_a), .overrun(ovr_a)
    );

    adc_spi_capture #(.CLK_DIV(4)) u_dut_b (
        .CLK50(clk), .MSS_RESET_N(rst_n), .start(start_b), .MISO(miso_b),
        .CS(cs_b), .SCLK(sclk_b), .sample(sample_b), .sample_valid(valid_b),
        .conv_complete(conv_b), .frame_err(ferr_b), .busy(busy_b), .overrun(ovr_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Behavioural ADC: next bit presented on each SCLK falling edge, MSB first
    always @(negedge cs_a) idx_a = 15;
    always @(negedge sclk_a) if (!cs_a) begin
        if (idx_a >= 0) begin
            miso_a = word_a[idx_a];
            idx_a--;
        end
        falls_a++;
    end

    always @(negedge cs_b) idx_b = 15;
    always @(negedge sclk_b) if (!cs_b) begin
        if (idx_b >= 0) begin
            miso_b = word_b[idx_b];
            idx_b--;
        end
        if (falls_b == 0) tf0_b = $time;
        if (falls_b == 1) tf1_b = $time;
        falls_b++;
    end

    always @(negedge clk) if (rst_n) begin
        chk("a_conv_eq_valid", {31'd0, conv_a}, {31'd0, valid_a});
        if (valid_a) begin
            chk("a_valid_expected", {31'd0, qa.size() != 0}, 32'd1);
            if (qa.size() != 0) begin
                ea = qa.pop_front();
                chk("a_sample", {20'd0, sample_a}, {20'd0, ea.smp});
                chk("a_frame_err", {31'd0, ferr_a}, {31'd0, ea.ferr});
                chk("a_valid_cycle", cyc, ea.at);
            end
        end
        if (ovr_a) begin
            ovr_cnt++;
            ovr_last = cyc;
        end
        if (prev_cs && !cs_a) cs_first = cyc;
        if (!prev_cs && cs_a) cs_last = cyc - 1;
        prev_cs = cs_a;
    end

    always @(negedge clk) if (rst_n) begin
        chk("b_conv_eq_valid", {31'd0, conv_b}, {31'd0, valid_b});
        if (valid_b) begin
            chk("b_valid_expected", {31'd0, qb.size() != 0}, 32'd1);
            if (qb.size() != 0) begin
                eb = qb.pop_front();
                chk("b_sample", {20'd0, sample_b}, {20'd0, eb.smp});
                chk("b_frame_err", {31'd0, ferr_b}, {31'd0, eb.ferr});
                chk("b_valid_cycle", cyc, eb.at);
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle_a(input string name, input int budget);
        int n = 0;
        while (busy_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, busy_a}, 32'd0);
    endtask

    task automatic fire_a(input logic [15:0] w, input logic [11:0] s, input logic fe,
                          input bit push, output int ts);
        ts      = cyc;
        word_a  = w;
        falls_a = 0;
        start_a = 1'b1;
        if (push) qa.push_back('{smp: s, ferr: fe, at: cyc + A_LAT});
        @(negedge clk);
        start_a = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time actual=%0t required<200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        miso_a = 1'b0; miso_b = 1'b0; word_a = '0; word_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs", {31'd0, cs_a}, 32'd1);
        chk("rst_sclk", {31'd0, sclk_a}, 32'd1);
        chk("rst_sample", {20'd0, sample_a}, 32'd0);
        chk("rst_strobes", {29'd0, valid_a, conv_a, ferr_a}, 32'd0);
        chk("rst_busy_ovr", {30'd0, busy_a, ovr_a}, 32'd0);
        chk("rst_b_cs_sclk", {30'd0, cs_b, sclk_b}, 32'd3);
        rst_n = 1'b1;

        // Basic frame, cs window and edge count
        wait_until(10);
        fire_a(16'h0A5C, 12'hA5C, 1'b0, 1'b1, t);
        wait_idle_a("t1_idle_timeout", 400);
        chk("t1_cs_first", cs_first, t + 1);
        chk("t1_cs_last", cs_last, t + A_LAT - 1);
        chk("t1_sclk_falls", falls_a, 32'd16);
        chk("t1_sample_hold", {20'd0, sample_a}, 32'hA5C);
        chk("t1_queue_empty", qa.size(), 32'd0);

        // Non-zero leading field
        fire_a(16'h8123, 12'h123, 1'b1, 1'b1, t);
        wait_idle_a("t2_idle_timeout", 400);
        chk("t2_queue_empty", qa.size(), 32'd0);

        // Held start: back-to-back frames, no overrun
        ov0     = ovr_cnt;
        t       = cyc;
        word_a  = 16'h0321;
        start_a = 1'b1;
        for (int k = 0; k * A_PER < 300; k++)
            qa.push_back('{smp: 12'h321, ferr: 1'b0, at: t + A_LAT + k * A_PER});
        wait_until(t + 300);
        start_a = 1'b0;
        wait_idle_a("t3_idle_timeout", 400);
        chk("t3_queue_empty", qa.size(), 32'd0);
        chk("t3_no_overrun", ovr_cnt, ov0);

        // Rising start mid-frame
        @(negedge clk);
        ov0 = ovr_cnt;
        fire_a(16'h0C0D, 12'hC0D, 1'b0, 1'b1, t);
        wait_until(t + 20);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_until(t + A_PER - 1);
        chk("t4_busy_last_quiet", {31'd0, busy_a}, 32'd1);
        @(negedge clk);
        chk("t4_busy_first_idle", {31'd0, busy_a}, 32'd0);
        chk("t4_overrun_count", ovr_cnt, ov0 + 1);
        chk("t4_overrun_cycle", ovr_last, t + 21);

        // Rising start in the last quiet cycle: flagged, not queued
        @(negedge clk);
        fire_a(16'h0055, 12'h055, 1'b0, 1'b1, t);
        wait_until(t + A_PER - 1);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4b_overrun_cycle", ovr_last, t + A_PER);
        chk("t4b_overrun_count", ovr_cnt, ov0 + 2);
        chk("t4b_not_queued", {31'd0, busy_a}, 32'd0);
        repeat (100) @(negedge clk);
        chk("t4b_queue_empty", qa.size(), 32'd0);

        // Reset during bit 7
        fire_a(16'hFFFF, 12'hFFF, 1'b0, 1'b0, t);
        wait_until(t + 2 + 15 * A_DIV);
        rst_n = 1'b0;
        #1;
        chk("t5_cs_async", {31'd0, cs_a}, 32'd1);
        chk("t5_sclk_async", {31'd0, sclk_a}, 32'd1);
        chk("t5_sample_cleared", {20'd0, sample_a}, 32'd0);
        chk("t5_no_valid_busy", {30'd0, valid_a, busy_a}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        fire_a(16'h0ABC, 12'hABC, 1'b0, 1'b1, t);
        wait_idle_a("t5_idle_timeout", 400);
        chk("t5_queue_empty", qa.size(), 32'd0);

        // Slow SCLK instance
        @(negedge clk);
        word_b  = 16'h0FFF;
        falls_b = 0;
        start_b = 1'b1;
        qb.push_back('{smp: 12'hFFF, ferr: 1'b0, at: cyc + B_LAT});
        @(negedge clk);
        start_b = 1'b0;
        for (int n = 0; n < 400 && busy_b; n++) @(negedge clk);
        chk("t6_idle_timeout", {31'd0, busy_b}, 32'd0);
        chk("t6_sclk_period", 32'((tf1_b - tf0_b) / 10), 32'd8);
        chk("t6_sclk_falls", falls_b, 32'd16);
        chk("t6_queue_empty", qb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
